cpu_cycle_sequencer: RTL and testbench

- Generates the one-hot `state[3:0]` bus (bit0 FETCH, bit1 EXEC1, bit2 EXEC2, bit3 EXEC3) that drives the instruction decoder.
- Chooses each instruction's path from the decoder's `e` (needs EXEC2) and `m` (needs EXEC3, multiply) outputs.
- Inserts hidden wait cycles for slow fetch and multiply.
- Provides run, single-step and halt control, plus a retired-instruction counter.

---
 rtl/cpu_cycle_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_cycle_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_cycle_sequencer.sv
// Instruction phase sequencer: one-hot FETCH/EXEC1/EXEC2/EXEC3 with hidden fetch/multiply waits.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module cpu_cycle_sequencer #(
   parameter int unsigned FETCH_WAIT = 0,
   parameter int unsigned MUL_LAT    = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic             e,
   input  logic             m,
   output logic [3:0]       state,
   output logic             busy,
   output logic             halted,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired_count
);

   localparam int unsigned MaxWait = (FETCH_WAIT > MUL_LAT) ? FETCH_WAIT : MUL_LAT;
   localparam int unsigned WaitW   = (MaxWait > 1) ? $clog2(MaxWait) : 1;

   // Last count value of each wait window; unused when the matching latency is zero.
   localparam logic [WaitW-1:0] FetchLast = WaitW'(FETCH_WAIT - 1);
   localparam logic [WaitW-1:0] MulLast   = WaitW'(MUL_LAT - 1);

   typedef enum logic [2:0] {
      StIdle, StWaitF, StFetch, StExec1, StExec2, StWaitM, StExec3, StHalted
   } seq_state_e;

   localparam seq_state_e StLaunch = (FETCH_WAIT > 0) ? StWaitF : StFetch;
   localparam seq_state_e StMulGo  = (MUL_LAT > 0) ? StWaitM : StExec3;

   seq_state_e       st_q, st_d, end_st;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [3:0]       state_d;
   logic             busy_d, halted_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q   <= StIdle;
         wait_q <= '0;
         state  <= 4'b0000;
         busy   <= 1'b0;
         halted <= 1'b0;
      end else begin
         st_q   <= st_d;
         wait_q <= wait_d;
         state  <= state_d;
         busy   <= busy_d;
         halted <= halted_d;
      end
   end

   // Where an instruction goes after its final visible phase.
   always_comb begin
      if (halt_req) begin
         end_st = StHalted;
      end else if (run) begin
         end_st = StLaunch;
      end else begin
         end_st = StIdle;
      end
   end

   always_comb begin
      st_d   = st_q;
      wait_d = '0;
      unique case (st_q)
         StIdle: begin
            if (halt_req) begin
               st_d = StHalted;
            end else if (run || step) begin
               st_d = StLaunch;
            end
         end
         StWaitF: begin
            if (wait_q == FetchLast) begin
               st_d = StFetch;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StFetch:  st_d = StExec1;
         StExec1:  st_d = e ? StExec2 : end_st;
         StExec2:  st_d = m ? StMulGo : end_st;
         StWaitM: begin
            if (wait_q == MulLast) begin
               st_d = StExec3;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StExec3:  st_d = end_st;
         StHalted: st_d = StHalted;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with st_q.
   always_comb begin
      state_d = 4'b0000;
      unique case (st_d)
         StFetch: state_d = 4'b0001;
         StExec1: state_d = 4'b0010;
         StExec2: state_d = 4'b0100;
         StExec3: state_d = 4'b1000;
         default: state_d = 4'b0000;
      endcase
      busy_d     = (st_d != StIdle) && (st_d != StHalted);
      halted_d   = (st_d == StHalted);
      instr_done = ((st_q == StExec1) && !e) || ((st_q == StExec2) && !m) || (st_q == StExec3);
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (instr_done) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign retired_count = cnt_q;
`else
   assign retired_count = '0;
`endif

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer: dut0 (FETCH_WAIT=0, MUL_LAT=2) and
// dut1 (FETCH_WAIT=3, MUL_LAT=0, CNT_W=2) share all inputs.
module tb_cpu_cycle_sequencer;

`ifdef SEQ_PERF_CNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic clk, reset, run, step, halt_req, e, m;
   logic [3:0]  st0, st1;
   logic        busy0, busy1, halted0, halted1, done0, done1;
   logic [15:0] cnt0;
   logic [1:0]  cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   cpu_cycle_sequencer #(.FETCH_WAIT(0), .MUL_LAT(2), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .e(e), .m(m),
      .state(st0), .busy(busy0), .halted(halted0), .instr_done(done0), .retired_count(cnt0)
   );

   cpu_cycle_sequencer #(.FETCH_WAIT(3), .MUL_LAT(0), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .e(e), .m(m),
      .state(st1), .busy(busy1), .halted(halted1), .instr_done(done1), .retired_count(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_cnt(input int n);
      return PerfEn ? n : 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; e = 1'b0; m = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; run = 1'b1; step = 1'b0; halt_req = 1'b0; e = 1'b1; m = 1'b1;
      tick();
      do_reset();
      n_tests++;
      if (st0 !== 4'b0000) begin n_fail++; $display("FAIL reset_state0: got %b want 0000", st0); end
      n_tests++;
      if (busy0 !== 1'b0 || halted0 !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags0: busy %b halted %b want 0 0", busy0, halted0);
      end
      n_tests++;
      if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_count0: got %0d want 0", cnt0); end
      n_tests++;
      if (st1 !== 4'b0000 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_state1: got %b busy %b want 0000 0", st1, busy1);
      end
   endtask

   task automatic test_free_run_jmp();
      do_reset();
      run = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_tests++;
         if (st0 !== ((k % 2 == 1) ? 4'b0001 : 4'b0010) || done0 !== (k % 2 == 0) || busy0 !== 1'b1)
         begin
            n_fail++;
            $display("FAIL jmp_phase[%0d]: got st %b done %b busy %b want st %b done %b busy 1", k,
                     st0, done0, busy0, (k % 2 == 1) ? 4'b0001 : 4'b0010, (k % 2 == 0));
         end
         n_tests++;
         if (cnt0 !== 16'(exp_cnt((k - 1) / 2))) begin
            n_fail++; $display("FAIL jmp_count[%0d]: got %0d want %0d", k, cnt0, exp_cnt((k - 1) / 2));
         end
      end
      tick();
      n_tests++;
      if (cnt0 !== 16'(exp_cnt(3))) begin
         n_fail++; $display("FAIL jmp_count_final: got %0d want %0d", cnt0, exp_cnt(3));
      end
   endtask

   task automatic test_mul_wait();
      logic [3:0] xs [13];
      xs = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0001,
             4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
      do_reset();
      run = 1'b1; e = 1'b1; m = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         n_tests++;
         if (st0 !== xs[k-1] || done0 !== (xs[k-1] == 4'b1000) || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_phase[%0d]: got st %b done %b busy %b want st %b done %b busy 1", k,
                     st0, done0, busy0, xs[k-1], (xs[k-1] == 4'b1000));
         end
         n_tests++;
         if (cnt0 !== 16'(exp_cnt((k - 1) / 6))) begin
            n_fail++; $display("FAIL mul_count[%0d]: got %0d want %0d", k, cnt0, exp_cnt((k - 1) / 6));
         end
      end
   endtask

   task automatic test_step();
      logic [3:0] xs [5];
      logic       sv [5];
      xs = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
      sv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      e = 1'b1; m = 1'b0; step = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         step = sv[k-1];
         n_tests++;
         if (st0 !== xs[k-1] || done0 !== (k == 3) || busy0 !== (k <= 3)) begin
            n_fail++;
            $display("FAIL step_phase[%0d]: got st %b done %b busy %b want st %b done %b busy %b",
                     k, st0, done0, busy0, xs[k-1], (k == 3), (k <= 3));
         end
      end
      n_tests++;
      if (cnt0 !== 16'(exp_cnt(1))) begin
         n_fail++; $display("FAIL step_count: got %0d want %0d", cnt0, exp_cnt(1));
      end
   endtask

   task automatic test_halt();
      do_reset();
      run = 1'b1; e = 1'b1; m = 1'b0;
      tick();
      tick();
      halt_req = 1'b1;
      n_tests++;
      if (st0 !== 4'b0010 || done0 !== 1'b0) begin
         n_fail++; $display("FAIL halt_exec1: got st %b done %b want 0010 0", st0, done0);
      end
      tick();
      n_tests++;
      if (st0 !== 4'b0100 || done0 !== 1'b1 || halted0 !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_exec2: got st %b done %b halted %b want 0100 1 0", st0, done0, halted0);
      end
      tick();
      halt_req = 1'b0; step = 1'b1;
      n_tests++;
      if (st0 !== 4'b0000 || halted0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 16'(exp_cnt(1))) begin
         n_fail++;
         $display("FAIL halt_enter: got st %b halted %b busy %b cnt %0d want 0000 1 0 %0d",
                  st0, halted0, busy0, cnt0, exp_cnt(1));
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         step = (k % 2 == 1);
         n_tests++;
         if (st0 !== 4'b0000 || halted0 !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky[%0d]: got st %b halted %b want 0000 1", k, st0, halted0);
         end
      end
      do_reset();
      n_tests++;
      if (halted0 !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got %b want 0", halted0); end
      halt_req = 1'b1; run = 1'b1;
      tick();
      n_tests++;
      if (st0 !== 4'b0000 || halted0 !== 1'b1 || halted1 !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_idle: got st %b halted0 %b halted1 %b want 0000 1 1", st0, halted0, halted1);
      end
   endtask

   task automatic test_fetch_wait();
      logic [3:0] xs [9];
      logic [3:0] ys [8];
      xs = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      ys = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      do_reset();
      run = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_tests++;
         if (st1 !== xs[k-1] || done1 !== (k == 5) || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL fwait_phase[%0d]: got st %b done %b busy %b want st %b done %b busy 1",
                     k, st1, done1, busy1, xs[k-1], (k == 5));
         end
      end
      n_tests++;
      if (cnt1 !== 2'(exp_cnt(1))) begin
         n_fail++; $display("FAIL fwait_count: got %0d want %0d", cnt1, exp_cnt(1));
      end
      do_reset();
      run = 1'b1; e = 1'b1; m = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_tests++;
         if (st1 !== ys[k-1] || done1 !== (k == 7) || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL nomulwait_phase[%0d]: got st %b done %b busy %b want st %b done %b busy 1",
                     k, st1, done1, busy1, ys[k-1], (k == 7));
         end
      end
   endtask

   task automatic test_count_wrap();
      do_reset();
      run = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 16 || k == 21) begin
            n_tests++;
            if (cnt1 !== 2'(exp_cnt(((k - 1) / 5) % 4))) begin
               n_fail++;
               $display("FAIL wrap_count[%0d]: got %0d want %0d", k, cnt1, exp_cnt(((k - 1) / 5) % 4));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run = 1'b1; e = 1'b1; m = 1'b1;
      for (int k = 1; k <= 10; k++) tick();
      n_tests++;
      if (st0 !== 4'b0000 || busy0 !== 1'b1 || cnt0 !== 16'(exp_cnt(1))) begin
         n_fail++;
         $display("FAIL rmid_waitm: got st %b busy %b cnt %0d want 0000 1 %0d", st0, busy0, cnt0,
                  exp_cnt(1));
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if (st0 !== 4'b0000 || busy0 !== 1'b0 || cnt0 !== 16'd0) begin
         n_fail++; $display("FAIL rmid_reset: got st %b busy %b cnt %0d want 0000 0 0", st0, busy0, cnt0);
      end
      tick();
      n_tests++;
      if (st0 !== 4'b0001) begin n_fail++; $display("FAIL rmid_restart0: got %b want 0001", st0); end
      tick();
      n_tests++;
      if (st0 !== 4'b0010) begin n_fail++; $display("FAIL rmid_restart1: got %b want 0010", st0); end
   endtask

   task automatic test_back_to_back();
      logic       ev [12];
      logic       mv [12];
      logic       rv [12];
      logic [3:0] xs [12];
      logic       dv [12];
      ev = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
      mv = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      rv = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      xs = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0001,
             4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
      dv = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
      do_reset();
      run = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         e = ev[k-1]; m = mv[k-1]; run = rv[k-1];
         #1;
         n_tests++;
         if (st0 !== xs[k-1] || done0 !== dv[k-1] || busy0 !== (k != 12)) begin
            n_fail++;
            $display("FAIL b2b_phase[%0d]: got st %b done %b busy %b want st %b done %b busy %b",
                     k, st0, done0, busy0, xs[k-1], dv[k-1], (k != 12));
         end
      end
      n_tests++;
      if (cnt0 !== 16'(exp_cnt(3))) begin
         n_fail++; $display("FAIL b2b_count: got %0d want %0d", cnt0, exp_cnt(3));
      end
   endtask

   initial begin
      test_reset();
      test_free_run_jmp();
      test_mul_wait();
      test_step();
      test_halt();
      test_fetch_wait();
      test_count_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
